gcd_req_arbiter: RTL
====================

GCD_REQ_ARBITER -- requirements
Module: gcd_req_arbiter

Interface
REQ-001 Parameter: W, default 16, operand/result bit width.
REQ-002 Port: clk  input  1  clock; all state updates on posedge.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: req0_val  input  1  requester 0 operand pair valid.
REQ-005 Port: req0_rdy  output  1  requester 0 operand pair accepted.
REQ-006 Port: req0_bits  input  2*W  requester 0 operands, {A,B}, A in upper half.
REQ-007 Port: req1_val / req1_rdy / req1_bits  input / output / input  1 / 1 / 2*W  requester 1, same meaning as REQ-004..006.
REQ-008 Port: resp0_val  output  1  result for requester 0 valid.
REQ-009 Port: resp0_rdy  input  1  requester 0 accepts result.
REQ-010 Port: resp1_val / resp1_rdy  output / input  1 / 1  requester 1, same meaning as REQ-008..009.
REQ-011 Port: resp_bits  output  W  result value, shared by both response ports; equals gcd_result_bits.
REQ-012 Port: gcd_operands_val / gcd_operands_rdy / gcd_operands_bits  output / input / output  1 / 1 / 2*W  operand port to the shared GCD unit.
REQ-013 Port: gcd_result_val / gcd_result_rdy / gcd_result_bits  input / output / input  1 / 1 / W  result port from the shared GCD unit.

Function
REQ-014 A transfer on any val/rdy pair SHALL occur in a cycle where both val and rdy are high at the rising edge.
REQ-015 The block SHALL implement a two-state FSM: IDLE (no transaction outstanding) and WAIT (one transaction issued, result pending).
REQ-016 At most one transaction SHALL be outstanding in the GCD unit at any time.
REQ-017 In IDLE, the winner SHALL be chosen combinationally each cycle from the current req*_val and the priority pointer.
REQ-018 The winner's bits SHALL drive gcd_operands_bits, and gcd_operands_val SHALL equal the winner's val.
REQ-019 The winner's req*_rdy SHALL equal gcd_operands_rdy, and the loser's req*_rdy SHALL be 0.
REQ-020 If neither requester is valid, gcd_operands_val SHALL be 0 and gcd_operands_bits SHALL be req0_bits.
REQ-021 On an operand transfer in IDLE, the block SHALL register owner equal to the winner index and enter WAIT next cycle.
REQ-022 In WAIT, both req*_rdy and gcd_operands_val SHALL be 0.
REQ-023 In WAIT, resp[owner]_val SHALL equal gcd_result_val and the other resp*_val SHALL be 0.
REQ-024 In WAIT, gcd_result_rdy SHALL equal resp[owner]_rdy.
REQ-025 In IDLE, gcd_result_rdy and both resp*_val SHALL be 0.
REQ-026 On a result transfer in WAIT, the block SHALL return to IDLE next cycle.
REQ-027 On a result transfer in WAIT, the priority pointer SHALL update to favour the requester that is not owner.
REQ-028 A result transfer and a new operand issue SHALL NOT occur in the same cycle; back-to-back throughput is one transaction per (GCD latency + 2) cycles minimum.
REQ-029 If resp[owner]_rdy is held low, the block SHALL stall in WAIT indefinitely, holding owner.
REQ-030 If resp[owner]_rdy is held low, the block SHALL assert no req*_rdy.

Reset
REQ-031 While reset is high, the state SHALL be IDLE, owner SHALL be 0, and the priority pointer SHALL favour requester 0.
REQ-032 During reset, all outputs SHALL follow the IDLE rules with req0_rdy and req1_rdy forced to 0.
REQ-033 Reset asserted in WAIT SHALL abandon the outstanding transaction; the GCD unit is reset by the same signal.

Configuration
REQ-034 Macro GCD_ARB_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin per REQ-027.
REQ-035 Macro GCD_ARB_ROUND_ROBIN_EN undefined: arbitration SHALL be fixed priority, requester 0 always winning when valid, with no pointer state.

Verification
REQ-036 Single request: req0 {27,15}, other requester idle -> resp0_val with resp_bits=3; resp1_val stays 0.
REQ-037 Simultaneous requests: req0 {12,8} and req1 {49,21} valid in the same IDLE cycle -> RR build serves req0 first (4) and then req1 (7); fixed-priority build gives the same order.
REQ-038 Fairness: both requesters continuously valid for 4 transactions -> RR build grants 0,1,0,1; fixed-priority build grants 0,0,0,0, and req1 is never served while req0 stays valid.
REQ-039 Response backpressure: resp1_rdy held low for 10 cycles after a req1 {100,75} issue -> block stays in WAIT, req0_rdy stays 0, result 25 is held and transfers on the first cycle resp1_rdy=1.
REQ-040 Reset in WAIT: reset pulsed while req0 {1071,462} is outstanding -> no resp*_val afterwards; the next req1 {9,6} returns 3 on resp1.

Source files
------------

// File: rtl/gcd_req_arbiter.sv
// gcd_req_arbiter: shares one GCD unit between two requesters.
// At most one operand pair is in flight. Responses return to whichever
// requester issued the outstanding pair.
//
// Build option: define GCD_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, requester 0 always wins when valid and there is no pointer state.
//
// Handshake: every val/rdy pair transfers on a rising clk edge where both
// val and rdy are high. val never depends on its own rdy. The winner's
// req*_rdy is a combinational copy of gcd_operands_rdy, and gcd_result_rdy
// is a combinational copy of the owner's resp*_rdy.
//
// dbg_state exposes the FSM state for checkers (0 = IDLE, 1 = WAIT).
module gcd_req_arbiter #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_val,
  output logic           req0_rdy,
  input  logic [2*W-1:0] req0_bits,
  input  logic           req1_val,
  output logic           req1_rdy,
  input  logic [2*W-1:0] req1_bits,
  output logic           resp0_val,
  input  logic           resp0_rdy,
  output logic           resp1_val,
  input  logic           resp1_rdy,
  output logic [W-1:0]   resp_bits,
  output logic           gcd_operands_val,
  input  logic           gcd_operands_rdy,
  output logic [2*W-1:0] gcd_operands_bits,
  input  logic           gcd_result_val,
  output logic           gcd_result_rdy,
  input  logic [W-1:0]   gcd_result_bits,
  output logic           dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
`ifdef GCD_ARB_ROUND_ROBIN_EN
  logic   prio_q, prio_d;
`endif

  logic win;
  logic in_wait;
  logic op_xfer;
  logic res_xfer;

  // While reset is high the outputs behave as in IDLE, even on the first
  // reset cycle when state_q may still hold WAIT.
  assign in_wait   = (state_q == WAIT) && !reset;
  assign op_xfer   = gcd_operands_val && gcd_operands_rdy;
  assign res_xfer  = gcd_result_val && gcd_result_rdy;
  assign resp_bits = gcd_result_bits;
  assign dbg_state = (state_q == WAIT);

  // Winner selection: 1 means requester 1, 0 means requester 0 or nobody.
  always_comb begin
    win = 1'b0;
`ifdef GCD_ARB_ROUND_ROBIN_EN
    if (prio_q) win = req1_val;
    else        win = !req0_val && req1_val;
`else
    win = !req0_val && req1_val;
`endif
  end

  // Handshake steering for the operand and result paths.
  always_comb begin
    req0_rdy          = 1'b0;
    req1_rdy          = 1'b0;
    resp0_val         = 1'b0;
    resp1_val         = 1'b0;
    gcd_result_rdy    = 1'b0;
    gcd_operands_val  = 1'b0;
    gcd_operands_bits = req0_bits;
    if (!in_wait) begin
      gcd_operands_bits = win ? req1_bits : req0_bits;
      gcd_operands_val  = win ? req1_val  : req0_val;
      if (!reset) begin
        req0_rdy = !win && gcd_operands_rdy;
        req1_rdy =  win && gcd_operands_rdy;
      end
    end else begin
      resp0_val      = !owner_q && gcd_result_val;
      resp1_val      =  owner_q && gcd_result_val;
      gcd_result_rdy = owner_q ? resp1_rdy : resp0_rdy;
    end
  end

  // Next-state logic: issue in IDLE, retire the result in WAIT.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef GCD_ARB_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (op_xfer) begin
          state_d = WAIT;
          owner_d = win;
        end
      end
      WAIT: begin
        if (res_xfer) begin
          state_d = IDLE;
`ifdef GCD_ARB_ROUND_ROBIN_EN
          prio_d  = !owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
`ifdef GCD_ARB_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef GCD_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

endmodule
